// File: rtl/spi_accel_responder.sv
// SPI mode-3 slave that emulates the accelerometer register map (64 x 8 bit).
// Define SPI_RESP_MULTIBYTE_EN to enable auto-incrementing multi-byte transfers (MB bit).
module spi_accel_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_VALUE = 8'hE5,
    parameter logic [7:0]  BW_RATE_RST = 8'h0A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        act_event,
    output logic        cfg_wr,
    output logic [5:0]  cfg_addr,
    output logic [7:0]  cfg_data,
    output logic        frame_done
);
    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
    logic                   sclk_prev_q, csn_prev_q;
    logic                   sclk_s, csn_s, sdi_s;
    logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic                   byte_end, cmd_end, data_end, wr_hit, rd_clear, cont;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             shift_in_q;
    logic [7:0]             in_byte, shift_out_q, rd_data;
    logic                   is_read_q, active_q, sdo_q;
    logic [5:0]             addr_q, rd_addr;
    logic [7:0]             regs_q [64];
    logic                   pend_valid_q, smp_direct, smp_apply;
    logic [15:0]            pend_x_q, pend_y_q, pend_z_q, smp_x, smp_y, smp_z;
    logic                   cfg_wr_q, frame_done_q;
    logic [5:0]             cfg_addr_q;
    logic [7:0]             cfg_data_q;

    function automatic logic writable(input logic [5:0] a);
        return (a >= 6'h1D && a <= 6'h2F) || a == 6'h31;
    endfunction

    // Synchronizers reset to the bus idle levels so reset release creates no edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '1;
            csn_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b1;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~csn_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~csn_s;
    assign csn_fall  = ~csn_s & csn_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;

    assign in_byte  = {shift_in_q, sdi_s};
    assign byte_end = sclk_rise && (bit_cnt_q == 3'd7);
    assign cmd_end  = (state_q == StCmd) && byte_end;
    assign data_end = (state_q == StData) && byte_end && active_q;
    assign wr_hit   = data_end && !is_read_q && writable(addr_q);
    assign rd_clear = data_end && is_read_q && (addr_q == 6'h30);
    assign rd_addr  = (state_q == StCmd) ? in_byte[5:0] : addr_q + 6'd1;
    assign rd_data  = (rd_addr == 6'h00) ? DEVID_VALUE : regs_q[rd_addr];

`ifdef SPI_RESP_MULTIBYTE_EN
    logic mb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mb_q <= 1'b0;
        end else if (cmd_end) begin
            mb_q <= in_byte[6];
        end
    end

    assign cont = mb_q;
`else
    assign cont = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (csn_rise) begin
            state_d = StIdle;
        end else if (csn_fall) begin
            state_d = StCmd;
        end else if (cmd_end) begin
            state_d = StData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            is_read_q   <= 1'b0;
            active_q    <= 1'b0;
            addr_q      <= '0;
            sdo_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (csn_fall) begin
                bit_cnt_q <= '0;
                sdo_q     <= 1'b0;
                active_q  <= 1'b0;
            end else if (csn_rise) begin
                sdo_q       <= 1'b0;
                active_q    <= 1'b0;
                shift_out_q <= '0;
            end else if (state_q != StIdle) begin
                if (sclk_rise) begin
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    shift_in_q <= in_byte[6:0];
                end
                if (cmd_end) begin
                    is_read_q   <= in_byte[7];
                    addr_q      <= in_byte[5:0];
                    active_q    <= 1'b1;
                    shift_out_q <= in_byte[7] ? rd_data : 8'h00;
                end else if (data_end) begin
                    if (cont) begin
                        addr_q      <= addr_q + 6'd1;
                        shift_out_q <= is_read_q ? rd_data : 8'h00;
                    end else begin
                        // Only the first data byte acts; the rest of the frame shifts zeros.
                        active_q    <= 1'b0;
                        shift_out_q <= '0;
                    end
                end else if (sclk_fall && state_q == StData) begin
                    sdo_q       <= shift_out_q[7];
                    shift_out_q <= {shift_out_q[6:0], 1'b0};
                end
            end
        end
    end

    // Strobes during a frame are parked so a frame never sees a mixed sample set.
    assign smp_direct = sample_valid && csn_s;
    assign smp_apply  = smp_direct || (csn_rise && pend_valid_q);
    assign smp_x      = smp_direct ? sample_x : pend_x_q;
    assign smp_y      = smp_direct ? sample_y : pend_y_q;
    assign smp_z      = smp_direct ? sample_z : pend_z_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) begin
                regs_q[i[5:0]] <= (i == 'h2C) ? BW_RATE_RST : 8'h00;
            end
            pend_valid_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_z_q     <= '0;
        end else begin
            if (wr_hit) begin
                regs_q[addr_q] <= in_byte;
            end
            if (rd_clear) begin
                regs_q[6'h30][4] <= 1'b0;
            end
            if (act_event) begin
                regs_q[6'h30][4] <= 1'b1;
            end
            if (csn_rise) begin
                pend_valid_q <= 1'b0;
            end
            if (sample_valid && !csn_s) begin
                pend_valid_q <= 1'b1;
                pend_x_q     <= sample_x;
                pend_y_q     <= sample_y;
                pend_z_q     <= sample_z;
            end
            if (smp_apply) begin
                regs_q[6'h32] <= smp_x[7:0];
                regs_q[6'h33] <= smp_x[15:8];
                regs_q[6'h34] <= smp_y[7:0];
                regs_q[6'h35] <= smp_y[15:8];
                regs_q[6'h36] <= smp_z[7:0];
                regs_q[6'h37] <= smp_z[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_wr_q     <= 1'b0;
            cfg_addr_q   <= '0;
            cfg_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cfg_wr_q     <= wr_hit;
            frame_done_q <= csn_rise;
            if (wr_hit) begin
                cfg_addr_q <= addr_q;
                cfg_data_q <= in_byte;
            end
        end
    end

    assign spi_sdo    = sdo_q;
    assign cfg_wr     = cfg_wr_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_data   = cfg_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Scoreboard bench for spi_accel_responder: a bit-banged mode-3 master feeds directed frames.
// Expected SDO bytes and cfg writes are queued up front; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_spi_accel_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sclk = 1'b1;
    logic        spi_csn = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_x = '0;
    logic [15:0] sample_y = '0;
    logic [15:0] sample_z = '0;
    logic        act_event = 1'b0;
    logic        cfg_wr;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        frame_done;

    int          n_chk = 0;
    int          n_fail = 0;
    int          fd_cnt = 0;
    int          exp_fd = 0;
    logic [7:0]  exp_rx [$];
    string       exp_nm [$];
    logic [7:0]  rx_got [$];
    logic [13:0] exp_cfg [$];
    logic [7:0]  mb_exp [6];

    spi_accel_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_sclk     (spi_sclk),
        .spi_csn      (spi_csn),
        .spi_sdi      (spi_sdi),
        .spi_sdo      (spi_sdo),
        .sample_valid (sample_valid),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .act_event    (act_event),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic [13:0] ec;
        logic [7:0]  er;
        logic [7:0]  gr;
        string       nm;
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (reset_n && cfg_wr) begin
                n_chk++;
                if (exp_cfg.size() == 0) begin
                    n_fail++;
                    $display("FAIL cfg_wr_unexpected: got addr=%02h data=%02h, required no pulse",
                             cfg_addr, cfg_data);
                end else begin
                    ec = exp_cfg.pop_front();
                    if ({cfg_addr, cfg_data} !== ec) begin
                        n_fail++;
                        $display("FAIL cfg_wr: got addr=%02h data=%02h, required addr=%02h data=%02h",
                                 cfg_addr, cfg_data, ec[13:8], ec[7:0]);
                    end
                end
            end
            while (rx_got.size() > 0) begin
                gr = rx_got.pop_front();
                n_chk++;
                if (exp_rx.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_unexpected: got %02h, required none", gr);
                end else begin
                    er = exp_rx.pop_front();
                    nm = exp_nm.pop_front();
                    if (gr !== er) begin
                        n_fail++;
                        $display("FAIL %s: got %02h, required %02h", nm, gr, er);
                    end
                end
            end
        end
    endtask

    task automatic half();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic expect_rx(input string nm, input logic [7:0] v);
        exp_nm.push_back(nm);
        exp_rx.push_back(v);
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        half();
    endtask

    task automatic cs_high();
        spi_csn = 1'b1;
        exp_fd++;
        repeat (3) half();
    endtask

    // act_end raises act_event so it lands on the same clock the DUT sees the 8th rise.
    task automatic xb(input logic [7:0] tx, input int nbits, input bit act_end, input bit chk_rx);
        logic [7:0] rx;
        rx = '0;
        for (int b = 0; b < nbits; b++) begin
            spi_sclk = 1'b0;
            spi_sdi  = tx[3'(7 - b)];
            half();
            rx[3'(7 - b)] = spi_sdo;
            spi_sclk = 1'b1;
            if (act_end && b == 7) begin
                repeat (2) @(posedge clk);
                #1 act_event = 1'b1;
                @(posedge clk);
                #1 act_event = 1'b0;
                repeat (5) @(posedge clk);
                #1;
            end else begin
                half();
            end
        end
        if (chk_rx) rx_got.push_back(rx);
    endtask

    task automatic rd1(input logic [7:0] cmd, input logic [7:0] exp, input string nm,
                       input bit act_end);
        expect_rx({nm, "_cmd"}, 8'h00);
        expect_rx(nm, exp);
        cs_low();
        xb(cmd, 8, 1'b0, 1'b1);
        xb(8'h00, 8, act_end, 1'b1);
        cs_high();
    endtask

    task automatic wr1(input logic [7:0] cmd, input logic [7:0] data, input bit hit,
                       input string nm);
        if (hit) exp_cfg.push_back({cmd[5:0], data});
        expect_rx({nm, "_cmd"}, 8'h00);
        cs_low();
        xb(cmd, 8, 1'b0, 1'b1);
        xb(data, 8, 1'b0, 1'b0);
        cs_high();
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(posedge clk);
        #1;
        sample_x = x;
        sample_y = y;
        sample_z = z;
        sample_valid = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic act_pulse();
        @(posedge clk);
        #1 act_event = 1'b1;
        @(posedge clk);
        #1 act_event = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        #23 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_sdo", {15'd0, spi_sdo}, 16'h0);
        chk("rst_cfg_wr", {15'd0, cfg_wr}, 16'h0);
        chk("rst_cfg_addr", {10'd0, cfg_addr}, 16'h0);
        chk("rst_cfg_data", {8'd0, cfg_data}, 16'h0);
        chk("rst_frame_done", {15'd0, frame_done}, 16'h0);

        rd1(8'h80, 8'hE5, "devid", 1'b0);
        rd1(8'hAC, 8'h0A, "bw_rate_rst", 1'b0);

        wr1(8'h2D, 8'h08, 1'b1, "wr_2d");
        rd1(8'hAD, 8'h08, "rd_2d", 1'b0);
        wr1(8'h00, 8'h55, 1'b0, "wr_devid");
        rd1(8'h80, 8'hE5, "devid_kept", 1'b0);
        wr1(8'h31, 8'h0B, 1'b1, "wr_31");
        rd1(8'hB1, 8'h0B, "rd_31", 1'b0);

        strobe(16'h1234, 16'h0000, 16'h0000);
        rd1(8'hB2, 8'h34, "x_lo", 1'b0);
        rd1(8'hB3, 8'h12, "x_hi", 1'b0);

        // Strobe lands mid-frame: this frame must still see the old Y value.
        expect_rx("midframe_cmd", 8'h00);
        expect_rx("y_lo_old", 8'h00);
        cs_low();
        strobe(16'h1234, 16'hBEEF, 16'h0000);
        xb(8'hB4, 8, 1'b0, 1'b1);
        xb(8'h00, 8, 1'b0, 1'b1);
        cs_high();
        rd1(8'hB4, 8'hEF, "y_lo_new", 1'b0);
        rd1(8'hB5, 8'hBE, "y_hi_new", 1'b0);

        act_pulse();
        rd1(8'hB0, 8'h10, "int_src_set", 1'b0);
        rd1(8'hB0, 8'h00, "int_src_clr", 1'b0);
        act_pulse();
        rd1(8'hB0, 8'h10, "int_src_coinc", 1'b1);
        rd1(8'hB0, 8'h10, "int_src_act_wins", 1'b0);

        chk("frames_a", 16'(fd_cnt), 16'(exp_fd));
        expect_rx("partial_cmd", 8'h00);
        cs_low();
        xb(8'h24, 8, 1'b0, 1'b1);
        xb(8'hFF, 5, 1'b0, 1'b0);
        cs_high();
        chk("partial_frame_done", 16'(fd_cnt), 16'(exp_fd));
        chk("partial_no_cfg", 16'(exp_cfg.size()), 16'h0);
        rd1(8'hA4, 8'h00, "partial_discard", 1'b0);

`ifdef SPI_RESP_MULTIBYTE_EN
        mb_exp = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
`else
        mb_exp = '{8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        strobe(16'h1234, 16'h5678, 16'h9ABC);
        expect_rx("burst_cmd", 8'h00);
        for (int i = 0; i < 6; i++) expect_rx($sformatf("burst_%0d", i), mb_exp[i]);
        cs_low();
        xb(8'hF2, 8, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) xb(8'h00, 8, 1'b0, 1'b1);
        cs_high();

        // Async reset mid-frame drops a parked sample and all register contents.
        cs_low();
        strobe(16'hAAAA, 16'hAAAA, 16'hAAAA);
        xb(8'hB2, 4, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        spi_csn = 1'b1;
        chk("rst_mid_sdo", {15'd0, spi_sdo}, 16'h0);
        reset_n = 1'b1;
        repeat (2) half();
        rd1(8'hB2, 8'h00, "rst_x_lo", 1'b0);
        rd1(8'hB3, 8'h00, "rst_pend_dropped", 1'b0);
        rd1(8'hAD, 8'h00, "rst_2d", 1'b0);
        rd1(8'hAC, 8'h0A, "rst_bw_rate", 1'b0);

        repeat (20) @(posedge clk);
        #1;
        chk("rx_all_seen", 16'(exp_rx.size()), 16'h0);
        chk("cfg_all_seen", 16'(exp_cfg.size()), 16'h0);
        chk("frames_end", 16'(fd_cnt), 16'(exp_fd));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
